// File: rtl/adder_pkg.sv
// Shared definitions for the 2-stage 33-bit adder and its result buffer.
//   OP_W        : adder operand width
//   SUM_W       : adder result width (operand width + carry bit)
//   ADD_LATENCY : clocks from operands at the adder inputs to out_sum valid
//   sum_t       : adder result type
package adder_pkg;

    localparam int unsigned OP_W        = 32;
    localparam int unsigned SUM_W       = OP_W + 1;
    localparam int unsigned ADD_LATENCY = 2;

    typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/sum_fifo_core.sv
// Synchronous FIFO storage for sum_result_buffer.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write wdata_i at the write pointer (caller guarantees space)
//   pop_i             : drop the head entry (caller guarantees non-empty)
//   rdata_o           : head entry, mem[rd_ptr]; reads as zero after reset
//   full_o, empty_o   : occupancy flags
//   level_o           : entries stored, 0..DEPTH
module sum_fifo_core
    import adder_pkg::*;
#(
    parameter  int unsigned DW    = SUM_W,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_i && !pop_i)      level_d = level_q + LW'(1);
        else if (!push_i && pop_i) level_d = level_q - LW'(1);
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (push_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/sum_result_buffer.sv
// Result buffer behind the 2-stage adder: delays operand-valid by the adder
// latency, captures the matching in_sum into a FIFO and issues credit-based
// op_ready so that no result is lost while upstream honours it.
// Optional feature macro: SUM_CARRY_CNT_EN (saturating count of stored
// results with the top bit set; carry_cnt reads 0 when undefined).
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   op_valid / op_ready   : operand pair at the adder inputs / credit available
//   in_sum                : adder out_sum
//   out_valid / out_ready : result handshake, out_data is the head entry
//   overflow              : sticky, a result was dropped
//   level                 : entries stored
//   carry_cnt             : stored results with bit SUM_W-1 set
module sum_result_buffer #(
    parameter  int unsigned SUM_W       = adder_pkg::SUM_W,
    parameter  int unsigned ADD_LATENCY = adder_pkg::ADD_LATENCY,
    parameter  int unsigned DEPTH       = 8,
    parameter  int unsigned CNT_W       = 16,
    localparam int unsigned LW          = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_data,
    output logic             overflow,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [ADD_LATENCY-1:0] dly_q, dly_d;
    logic                   overflow_q, overflow_d;
    logic                   acc, push_v, pop, push_ok, full, empty;
    int unsigned            inflight;

    // Credit: every accepted op already owns a slot, whether stored or still
    // travelling through the adder. Uses registered state only.
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < ADD_LATENCY; i++)
            inflight = inflight + 32'(dly_q[i]);
    end

    assign op_ready = (32'(level) + inflight) < DEPTH;
    assign acc      = op_valid & op_ready;

    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = acc;
        for (int unsigned i = 1; i < ADD_LATENCY; i++)
            dly_d[i] = dly_q[i-1];
    end

    assign push_v     = dly_q[ADD_LATENCY-1];
    assign out_valid  = ~empty;
    assign pop        = out_valid & out_ready;
    assign push_ok    = push_v & (~full | pop);
    assign overflow_d = overflow_q | (push_v & full & ~pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            dly_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            dly_q      <= dly_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    sum_fifo_core #(
        .DW    (SUM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (in_sum),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

`ifdef SUM_CARRY_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && in_sum[SUM_W-1] && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign carry_cnt = cnt_q;
`else
    assign carry_cnt = '0;
`endif

endmodule
